// File: rtl/sprite_color_mapper_pkg.sv
// Shared types and constants for the sprite colour mapper: shadow record layout,
// background colour constants and the object-count ceiling.
package sprite_color_mapper_pkg;

    localparam int MAX_OBJ     = 8;
    localparam int MAX_COORD_W = 16;
    localparam int MAX_COLOR_W = 16;

    localparam logic [7:0] BG_RED       = 8'h3F;
    localparam logic [7:0] BG_BASE_BLUE = 8'h3F;

    // Fields are sized for the widest supported configuration; instances use the low bits.
    typedef struct packed {
        logic [MAX_COORD_W-1:0]   x;
        logic [MAX_COORD_W-1:0]   y;
        logic [MAX_COORD_W-1:0]   size;
        logic [3*MAX_COLOR_W-1:0] color;
        logic                     en;
    } obj_shadow_t;

endpackage

// File: rtl/sprite_color_mapper_obj.sv
// Per-object hit test (pipeline stages 1-2): signed distance, then circle or square
// containment. Circle test when SPRITE_COLOR_MAPPER_CIRCLE_EN is defined, square otherwise.
module obj_hit_test
    import sprite_color_mapper_pkg::*;
#(
    parameter int COORD_W = 10
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [COORD_W-1:0] i_draw_x,
    input  logic [COORD_W-1:0] i_draw_y,
    input  logic [COORD_W-1:0] i_obj_x,
    input  logic [COORD_W-1:0] i_obj_y,
    input  logic [COORD_W-1:0] i_obj_size,
    input  logic               i_obj_en,
    output logic               o_in
);

    logic signed [COORD_W:0] r_dist_x_p1;
    logic signed [COORD_W:0] r_dist_y_p1;
    logic [COORD_W-1:0]      r_size_p1;
    logic                    r_en_p1;
    logic                    r_in_p2;
    logic                    w_in_next;

    // stage 1: distances to the shadow centre
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_dist_x_p1 <= '0;
            r_dist_y_p1 <= '0;
            r_size_p1   <= '0;
            r_en_p1     <= 1'b0;
        end else begin
            r_dist_x_p1 <= signed'({1'b0, i_draw_x}) - signed'({1'b0, i_obj_x});
            r_dist_y_p1 <= signed'({1'b0, i_draw_y}) - signed'({1'b0, i_obj_y});
            r_size_p1   <= i_obj_size;
            r_en_p1     <= i_obj_en;
        end
    end

`ifdef SPRITE_COLOR_MAPPER_CIRCLE_EN
    logic signed [2*COORD_W+1:0] w_dx_ext;
    logic signed [2*COORD_W+1:0] w_dy_ext;
    logic signed [2*COORD_W+1:0] w_sq_x;
    logic signed [2*COORD_W+1:0] w_sq_y;
    logic [2*COORD_W+2:0]        w_sum;
    logic [2*COORD_W-1:0]        w_size_ext;
    logic [2*COORD_W-1:0]        w_size_sq;

    assign w_dx_ext   = (2*COORD_W+2)'(r_dist_x_p1);
    assign w_dy_ext   = (2*COORD_W+2)'(r_dist_y_p1);
    assign w_sq_x     = w_dx_ext * w_dx_ext;
    assign w_sq_y     = w_dy_ext * w_dy_ext;
    assign w_sum      = {1'b0, w_sq_x} + {1'b0, w_sq_y};
    assign w_size_ext = (2*COORD_W)'(r_size_p1);
    assign w_size_sq  = w_size_ext * w_size_ext;
    assign w_in_next  = r_en_p1 && (w_sum <= (2*COORD_W+3)'(w_size_sq));
`else
    logic [COORD_W:0] w_abs_x;
    logic [COORD_W:0] w_abs_y;

    // |-2^COORD_W| still fits COORD_W+1 bits when read back as unsigned
    assign w_abs_x   = r_dist_x_p1[COORD_W] ? $unsigned(-r_dist_x_p1) : $unsigned(r_dist_x_p1);
    assign w_abs_y   = r_dist_y_p1[COORD_W] ? $unsigned(-r_dist_y_p1) : $unsigned(r_dist_y_p1);
    assign w_in_next = r_en_p1 && (w_abs_x <= {1'b0, r_size_p1}) && (w_abs_y <= {1'b0, r_size_p1});
`endif

    // stage 2: containment result
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_in_p2 <= 1'b0;
        end else begin
            r_in_p2 <= w_in_next;
        end
    end

    assign o_in = r_in_p2;

endmodule

// File: rtl/sprite_color_mapper.sv
// Composites NUM_OBJ circular/square objects over the gradient background with
// frame-synchronous shadow positions and a per-frame player collision flag.
// Shape test selected by SPRITE_COLOR_MAPPER_CIRCLE_EN (see obj_hit_test).
module sprite_color_mapper
    import sprite_color_mapper_pkg::*;
#(
    parameter int NUM_OBJ = 4,
    parameter int COORD_W = 10,
    parameter int COLOR_W = 8
) (
    input  logic                                Clk,
    input  logic                                Reset,
    input  logic                                frame_start,
    input  logic                                pix_valid,
    input  logic [COORD_W-1:0]                  DrawX,
    input  logic [COORD_W-1:0]                  DrawY,
    input  logic [NUM_OBJ-1:0][COORD_W-1:0]     obj_x,
    input  logic [NUM_OBJ-1:0][COORD_W-1:0]     obj_y,
    input  logic [NUM_OBJ-1:0][COORD_W-1:0]     obj_size,
    input  logic [NUM_OBJ-1:0][3*COLOR_W-1:0]   obj_color,
    input  logic [NUM_OBJ-1:0]                  obj_en,
    output logic [COLOR_W-1:0]                  Red,
    output logic [COLOR_W-1:0]                  Green,
    output logic [COLOR_W-1:0]                  Blue,
    output logic                                pix_valid_out,
    output logic                                hit,
    output logic [2:0]                          hit_idx,
    output logic                                collision
);

    obj_shadow_t              r_shadow [NUM_OBJ];
    logic [NUM_OBJ-1:0]       w_unused_shadow;
    logic [NUM_OBJ-1:0]       w_in_p2;
    logic [3*COLOR_W-1:0]     r_color_p1 [NUM_OBJ];
    logic [3*COLOR_W-1:0]     r_color_p2 [NUM_OBJ];
    logic                     r_vld_p1;
    logic                     r_vld_p2;
    logic [6:0]               r_xbg_p1;
    logic [6:0]               r_xbg_p2;
    logic                     w_win;
    logic [2:0]               w_idx;
    logic [3*COLOR_W-1:0]     w_rgb;

    function automatic logic [COLOR_W-1:0] bg_blue(input logic [6:0] xs);
        logic [7:0] b;
        b = BG_BASE_BLUE - {1'b0, xs};
        return COLOR_W'(b);
    endfunction

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_OBJ; i++) r_shadow[i] <= '0;
        end else if (frame_start) begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                r_shadow[i].x     <= MAX_COORD_W'(obj_x[i]);
                r_shadow[i].y     <= MAX_COORD_W'(obj_y[i]);
                r_shadow[i].size  <= MAX_COORD_W'(obj_size[i]);
                r_shadow[i].color <= (3*MAX_COLOR_W)'(obj_color[i]);
                r_shadow[i].en    <= obj_en[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_OBJ; g++) begin : g_obj
        assign w_unused_shadow[g] = ^r_shadow[g];

        obj_hit_test #(
            .COORD_W (COORD_W)
        ) u_hit (
            .Clk        (Clk),
            .Reset      (Reset),
            .i_draw_x   (DrawX),
            .i_draw_y   (DrawY),
            .i_obj_x    (r_shadow[g].x[COORD_W-1:0]),
            .i_obj_y    (r_shadow[g].y[COORD_W-1:0]),
            .i_obj_size (r_shadow[g].size[COORD_W-1:0]),
            .i_obj_en   (r_shadow[g].en),
            .o_in       (w_in_p2[g])
        );
    end

    // stages 1-2: pixel side-band travels beside the hit tests
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
            r_xbg_p1 <= '0;
            r_xbg_p2 <= '0;
            for (int i = 0; i < NUM_OBJ; i++) begin
                r_color_p1[i] <= '0;
                r_color_p2[i] <= '0;
            end
        end else begin
            r_vld_p1 <= pix_valid;
            r_vld_p2 <= r_vld_p1;
            r_xbg_p1 <= DrawX[9:3];
            r_xbg_p2 <= r_xbg_p1;
            for (int i = 0; i < NUM_OBJ; i++) begin
                r_color_p1[i] <= r_shadow[i].color[3*COLOR_W-1:0];
                r_color_p2[i] <= r_color_p1[i];
            end
        end
    end

    always_comb begin
        w_win = 1'b0;
        w_idx = 3'd0;
        w_rgb = {COLOR_W'(BG_RED), {COLOR_W{1'b0}}, bg_blue(r_xbg_p2)};
        // walk downward so the lowest covering index is the final assignment
        for (int k = NUM_OBJ - 1; k >= 0; k--) begin
            if (w_in_p2[k]) begin
                w_win = 1'b1;
                w_idx = 3'(k);
                w_rgb = r_color_p2[k];
            end
        end
    end

    // stage 3: registered pixel outputs with blanking
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Red           <= '0;
            Green         <= '0;
            Blue          <= '0;
            pix_valid_out <= 1'b0;
            hit           <= 1'b0;
            hit_idx       <= 3'd0;
        end else begin
            pix_valid_out <= r_vld_p2;
            if (r_vld_p2) begin
                Red     <= w_rgb[3*COLOR_W-1 -: COLOR_W];
                Green   <= w_rgb[2*COLOR_W-1 -: COLOR_W];
                Blue    <= w_rgb[COLOR_W-1:0];
                hit     <= w_win;
                hit_idx <= w_idx;
            end else begin
                Red     <= '0;
                Green   <= '0;
                Blue    <= '0;
                hit     <= 1'b0;
                hit_idx <= 3'd0;
            end
        end
    end

    if (NUM_OBJ > 1) begin : g_coll
        logic r_acc;
        logic w_overlap;

        assign w_overlap = r_vld_p2 && w_in_p2[0] && (|w_in_p2[NUM_OBJ-1:1]);

        always_ff @(posedge Clk) begin
            if (Reset) begin
                r_acc     <= 1'b0;
                collision <= 1'b0;
            end else if (frame_start) begin
                r_acc     <= 1'b0;
                collision <= r_acc | w_overlap;
            end else begin
                r_acc     <= r_acc | w_overlap;
            end
        end
    end else begin : g_no_coll
        assign collision = 1'b0;
    end

endmodule

// File: tb/tb_sprite_color_mapper.sv
// Directed bench for sprite_color_mapper: reset, hit/priority, shadow timing,
// collision framing, shape boundary, blanking and mid-frame reset.
module tb_sprite_color_mapper;

    localparam int NUM_OBJ = 4;
    localparam int COORD_W = 10;
    localparam int COLOR_W = 8;

    logic                              Clk;
    logic                              Reset;
    logic                              frame_start;
    logic                              pix_valid;
    logic [COORD_W-1:0]                DrawX;
    logic [COORD_W-1:0]                DrawY;
    logic [NUM_OBJ-1:0][COORD_W-1:0]   obj_x;
    logic [NUM_OBJ-1:0][COORD_W-1:0]   obj_y;
    logic [NUM_OBJ-1:0][COORD_W-1:0]   obj_size;
    logic [NUM_OBJ-1:0][3*COLOR_W-1:0] obj_color;
    logic [NUM_OBJ-1:0]                obj_en;
    logic [COLOR_W-1:0]                Red;
    logic [COLOR_W-1:0]                Green;
    logic [COLOR_W-1:0]                Blue;
    logic                              pix_valid_out;
    logic                              hit;
    logic [2:0]                        hit_idx;
    logic                              collision;

    int n_cmp;
    int n_err;

    sprite_color_mapper #(
        .NUM_OBJ (NUM_OBJ),
        .COORD_W (COORD_W),
        .COLOR_W (COLOR_W)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .frame_start   (frame_start),
        .pix_valid     (pix_valid),
        .DrawX         (DrawX),
        .DrawY         (DrawY),
        .obj_x         (obj_x),
        .obj_y         (obj_y),
        .obj_size      (obj_size),
        .obj_color     (obj_color),
        .obj_en        (obj_en),
        .Red           (Red),
        .Green         (Green),
        .Blue          (Blue),
        .pix_valid_out (pix_valid_out),
        .hit           (hit),
        .hit_idx       (hit_idx),
        .collision     (collision)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_pix(input string tag, input logic [7:0] r, input logic [7:0] g,
                           input logic [7:0] b, input logic h, input logic [2:0] idx);
        chk({tag, ".red"},   32'(Red),     32'(r));
        chk({tag, ".green"}, 32'(Green),   32'(g));
        chk({tag, ".blue"},  32'(Blue),    32'(b));
        chk({tag, ".hit"},   32'(hit),     32'(h));
        chk({tag, ".idx"},   32'(hit_idx), 32'(idx));
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input int x, input int y);
        DrawX     = COORD_W'(x);
        DrawY     = COORD_W'(y);
        pix_valid = 1'b1;
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        pix_valid   = 1'b0;
        tick();
        frame_start = 1'b0;
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        Reset       = 1'b1;
        frame_start = 1'b0;
        pix_valid   = 1'b1;
        DrawX       = '0;
        DrawY       = '0;
        obj_x       = '0;
        obj_y       = '0;
        obj_size    = '0;
        obj_color   = '0;
        obj_en      = '0;

        // reset held two cycles with pix_valid high
        tick();
        tick();
        chk_pix("rst", 8'h00, 8'h00, 8'h00, 1'b0, 3'd0);
        chk("rst.pvo", 32'(pix_valid_out), 32'd0);
        chk("rst.coll", 32'(collision), 32'd0);

        Reset = 1'b0;
        tick();
        tick();
        chk("rel2.pvo", 32'(pix_valid_out), 32'd0);
        chk("rel2.red", 32'(Red), 32'd0);
        tick();
        chk("rel3.pvo", 32'(pix_valid_out), 32'd1);
        chk_pix("rel3.bg", 8'h3F, 8'h00, 8'h3F, 1'b0, 3'd0);

        // object 0 edge and just outside
        obj_x[0] = 10'd100; obj_y[0] = 10'd100; obj_size[0] = 10'd10;
        obj_color[0] = 24'hFF0000; obj_en = 4'b0001;
        pulse_fs();
        drive(100, 110); tick();
        drive(100, 111); tick();
        pix_valid = 1'b0; tick();
        chk_pix("edge_in", 8'hFF, 8'h00, 8'h00, 1'b1, 3'd0);
        tick();
        chk_pix("edge_out", 8'h3F, 8'h00, 8'h33, 1'b0, 3'd0);

        // priority between coincident objects 1 and 2
        obj_x[1] = 10'd200; obj_y[1] = 10'd50; obj_size[1] = 10'd5; obj_color[1] = 24'h00FF00;
        obj_x[2] = 10'd200; obj_y[2] = 10'd50; obj_size[2] = 10'd5; obj_color[2] = 24'h0000FF;
        obj_en = 4'b0111;
        pulse_fs();
        drive(200, 50); tick();
        pix_valid = 1'b0; tick(); tick();
        chk_pix("prio", 8'h00, 8'hFF, 8'h00, 1'b1, 3'd1);

        // live move without frame_start is invisible
        obj_x[0] = 10'd300;
        drive(100, 100); tick();
        pix_valid = 1'b0; tick(); tick();
        chk_pix("stale", 8'hFF, 8'h00, 8'h00, 1'b1, 3'd0);

        // pixel in the frame_start cycle keeps the old shadow
        frame_start = 1'b1; drive(100, 100); tick();
        frame_start = 1'b0; drive(100, 100); tick();
        drive(300, 100); tick();
        pix_valid = 1'b0;
        chk_pix("fs_old", 8'hFF, 8'h00, 8'h00, 1'b1, 3'd0);
        tick();
        chk_pix("fs_new_miss", 8'h3F, 8'h00, 8'h33, 1'b0, 3'd0);
        tick();
        chk_pix("fs_new_hit", 8'hFF, 8'h00, 8'h00, 1'b1, 3'd0);
        chk("fs.coll", 32'(collision), 32'd0);

        // collision: overlap in frame N only
        obj_x[3] = 10'd300; obj_y[3] = 10'd100; obj_size[3] = 10'd5; obj_color[3] = 24'h808080;
        obj_en = 4'b1001;
        pulse_fs();
        chk("coll.pre", 32'(collision), 32'd0);
        drive(300, 100); tick();
        pix_valid = 1'b0; tick(); tick();
        chk_pix("ovl_pix", 8'hFF, 8'h00, 8'h00, 1'b1, 3'd0);
        tick();
        chk("coll.midN", 32'(collision), 32'd0);
        obj_x[3] = 10'd500;
        pulse_fs();
        chk("coll.endN", 32'(collision), 32'd1);
        drive(300, 100); tick();
        pix_valid = 1'b0; tick(); tick();
        chk_pix("noovl_pix", 8'hFF, 8'h00, 8'h00, 1'b1, 3'd0);
        chk("coll.hold", 32'(collision), 32'd1);
        pulse_fs();
        chk("coll.endN1", 32'(collision), 32'd0);

        // shape corner (10,10) and axis point just past the radius
        obj_x[0] = 10'd100; obj_en = 4'b0001;
        pulse_fs();
        drive(110, 110); tick();
        drive(111, 100); tick();
        pix_valid = 1'b0; tick();
`ifdef SPRITE_COLOR_MAPPER_CIRCLE_EN
        chk_pix("corner", 8'h3F, 8'h00, 8'h32, 1'b0, 3'd0);
`else
        chk_pix("corner", 8'hFF, 8'h00, 8'h00, 1'b1, 3'd0);
`endif
        tick();
        chk_pix("axis_out", 8'h3F, 8'h00, 8'h32, 1'b0, 3'd0);

        // blanking
        tick();
        chk_pix("blank", 8'h00, 8'h00, 8'h00, 1'b0, 3'd0);
        chk("blank.pvo", 32'(pix_valid_out), 32'd0);

        // reset mid-frame drops in-flight pixels and disables objects
        drive(100, 110); tick();
        Reset = 1'b1; tick();
        Reset = 1'b0;
        chk_pix("mrst", 8'h00, 8'h00, 8'h00, 1'b0, 3'd0);
        chk("mrst.pvo", 32'(pix_valid_out), 32'd0);
        tick(); tick();
        chk("mrst.drop", 32'(pix_valid_out), 32'd0);
        tick();
        chk_pix("mrst.bg", 8'h3F, 8'h00, 8'h33, 1'b0, 3'd0);
        chk("mrst.coll", 32'(collision), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
